// File: rtl/decode_stage.sv
// RV32I decode stage: decodes fetched instructions into control bits, register indices and
// a sign-extended immediate, buffered in a DEPTH-entry FIFO with valid/ready on both sides.
module decode_stage #(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 2,
    parameter int NUM_REGS = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] imm,
    output logic            mem_write,
    output logic            reg_write,
    output logic            alu_src,
    output logic [3:0]      alu_op,
    output logic            mem_to_reg,
    output logic            branch,
    output logic            jump,
    output logic            illegal
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic            memWrite;
        logic            regWrite;
        logic            aluSrc;
        logic [3:0]      aluOp;
        logic            memToReg;
        logic            branch;
        logic            jump;
        logic            illegal;
    } entry_t;

    entry_t         fifo_r [DEPTH];
    logic [PW-1:0]  wrPtr_r, rdPtr_r;
    logic [CW-1:0]  count_r, countNext_s;
    logic           inReady_r, outValid_r;
    logic           push_s, pop_s;
    entry_t         dec_s, head_s;
    logic           useRd_s, useRs1_s, useRs2_s, known_s, wantRegWrite_s, wantMemWrite_s;
    logic [31:0]    imm32_s;

    function automatic logic regOk(input logic [4:0] idx);
        return ({1'b0, idx} < 6'(NUM_REGS));
    endfunction

    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Combinational decode of the incoming instruction into a FIFO entry
    always_comb begin
        dec_s          = '0;
        dec_s.pc       = in_pc;
        useRd_s        = 1'b0;
        useRs1_s       = 1'b0;
        useRs2_s       = 1'b0;
        known_s        = 1'b1;
        wantRegWrite_s = 1'b0;
        wantMemWrite_s = 1'b0;
        imm32_s        = 32'd0;
        case (in_instr[6:0])
            7'b0000011: begin
                useRd_s = 1'b1; useRs1_s = 1'b1; wantRegWrite_s = 1'b1; dec_s.memToReg = 1'b1;
                imm32_s = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            7'b0100011: begin
                useRs1_s = 1'b1; useRs2_s = 1'b1; wantMemWrite_s = 1'b1;
                imm32_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end
            7'b0110011: begin
                useRd_s = 1'b1; useRs1_s = 1'b1; useRs2_s = 1'b1; wantRegWrite_s = 1'b1;
                dec_s.aluSrc = 1'b1;
                dec_s.aluOp  = {in_instr[30], in_instr[14:12]};
            end
            7'b0010011: begin
                useRd_s = 1'b1; useRs1_s = 1'b1; wantRegWrite_s = 1'b1;
                imm32_s = {{20{in_instr[31]}}, in_instr[31:20]};
                // Only SRAI carries funct7[5]; other OP-IMM immediates may have bit 30 set
                if (in_instr[14:12] == 3'b101 && in_instr[30]) begin
                    dec_s.aluOp = 4'b1101;
                end else begin
                    dec_s.aluOp = {1'b0, in_instr[14:12]};
                end
            end
            7'b1100011: begin
                useRs1_s = 1'b1; useRs2_s = 1'b1; dec_s.branch = 1'b1; dec_s.aluSrc = 1'b1;
                dec_s.aluOp = 4'b1000;
                imm32_s = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
            end
            7'b1101111: begin
                useRd_s = 1'b1; dec_s.jump = 1'b1; wantRegWrite_s = 1'b1;
                imm32_s = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
            end
            7'b1100111: begin
                useRd_s = 1'b1; useRs1_s = 1'b1; dec_s.jump = 1'b1; wantRegWrite_s = 1'b1;
                imm32_s = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            7'b0110111, 7'b0010111: begin
                useRd_s = 1'b1; wantRegWrite_s = 1'b1;
                imm32_s = {in_instr[31:12], 12'd0};
            end
            default: known_s = 1'b0;
        endcase
        dec_s.rd      = useRd_s  ? in_instr[11:7]  : 5'd0;
        dec_s.rs1     = useRs1_s ? in_instr[19:15] : 5'd0;
        dec_s.rs2     = useRs2_s ? in_instr[24:20] : 5'd0;
        dec_s.imm     = XLEN'($signed(imm32_s));
        dec_s.illegal = !known_s || (in_instr[1:0] != 2'b11) ||
                        !regOk(dec_s.rd) || !regOk(dec_s.rs1) || !regOk(dec_s.rs2);
        dec_s.regWrite = wantRegWrite_s && (dec_s.rd != 5'd0) && !dec_s.illegal;
        dec_s.memWrite = wantMemWrite_s && !dec_s.illegal;
    end

    assign push_s = in_valid && inReady_r;
    assign pop_s  = outValid_r && out_ready;

    // Occupancy after this cycle's push/pop
    always_comb begin
        countNext_s = count_r;
        case ({push_s, pop_s})
            2'b10:   countNext_s = count_r + CW'(1);
            2'b01:   countNext_s = count_r - CW'(1);
            default: countNext_s = count_r;
        endcase
    end

    // FIFO storage, pointers and registered handshake flags
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_r[i] <= '0;
            end
            wrPtr_r    <= '0;
            rdPtr_r    <= '0;
            count_r    <= '0;
            inReady_r  <= 1'b1;
            outValid_r <= 1'b0;
        end else if (flush) begin
            wrPtr_r    <= '0;
            rdPtr_r    <= '0;
            count_r    <= '0;
            inReady_r  <= 1'b1;
            outValid_r <= 1'b0;
        end else begin
            if (push_s) begin
                fifo_r[wrPtr_r] <= dec_s;
                wrPtr_r         <= nextPtr(wrPtr_r);
            end else begin
                wrPtr_r <= wrPtr_r;
            end
            if (pop_s) begin
                rdPtr_r <= nextPtr(rdPtr_r);
            end else begin
                rdPtr_r <= rdPtr_r;
            end
            count_r    <= countNext_s;
            inReady_r  <= (countNext_s < CW'(DEPTH));
            outValid_r <= (countNext_s != '0);
        end
    end

    // Head entry presented to execute, zeroed when empty
    always_comb begin
        if (outValid_r) begin
            head_s = fifo_r[rdPtr_r];
        end else begin
            head_s = '0;
        end
    end

    assign in_ready   = inReady_r;
    assign out_valid  = outValid_r;
    assign out_pc     = head_s.pc;
    assign rs1        = head_s.rs1;
    assign rs2        = head_s.rs2;
    assign rd         = head_s.rd;
    assign imm        = head_s.imm;
    assign mem_write  = head_s.memWrite;
    assign reg_write  = head_s.regWrite;
    assign alu_src    = head_s.aluSrc;
    assign alu_op     = head_s.aluOp;
    assign mem_to_reg = head_s.memToReg;
    assign branch     = head_s.branch;
    assign jump       = head_s.jump;
    assign illegal    = head_s.illegal;
endmodule
